// File: rtl/viterbi_sequencer_pkg.sv
// Shared types and widths for the Viterbi sequencer slice.
package viterbi_sequencer_pkg;

    localparam int unsigned CHAR_W = 5;
    localparam int unsigned PROB_W = 32;
    localparam int unsigned TOPK   = 3;
    localparam int unsigned SEQ_W  = 120;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ERR_W  = 2;

    typedef logic [TOPK-1:0][CHAR_W-1:0] char_arr_t;
    typedef logic [TOPK-1:0][PROB_W-1:0] prob_arr_t;
    typedef logic [SEQ_W-1:0]            seq_t;
    typedef logic [LEN_W-1:0]            len_t;

    typedef struct packed {
        char_arr_t chars;
        prob_arr_t probs;
        logic      last;
    } frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/viterbi_sequencer_if.sv
// Classifier-side frame handshake, Viterbi operand/step channel and word result.
interface viterbi_sequencer_if;
    import viterbi_sequencer_pkg::*;

    logic      frm_valid;
    logic      frm_ready;
    char_arr_t frm_char;
    prob_arr_t frm_prob;
    logic      frm_last;

    logic      vit_start;
    logic      vit_next;
    char_arr_t vit_char;
    prob_arr_t vit_prob;
    logic      vit_stepped;
    seq_t      vit_seq;

    logic             seq_valid;
    seq_t             seq;
    len_t             len;
    logic [ERR_W-1:0] err;

    modport master (
        output frm_valid, frm_char, frm_prob, frm_last, vit_stepped, vit_seq,
        input  frm_ready, vit_start, vit_next, vit_char, vit_prob,
               seq_valid, seq, len, err
    );

    modport slave (
        input  frm_valid, frm_char, frm_prob, frm_last, vit_stepped, vit_seq,
        output frm_ready, vit_start, vit_next, vit_char, vit_prob,
               seq_valid, seq, len, err
    );
endinterface

// File: rtl/viterbi_sequencer_frame_fifo.sv
// Synchronous frame FIFO with registered full/empty flags and a flush input.
module viterbi_sequencer_frame_fifo
    import viterbi_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  frame_t din,
    input  logic   pop,
    output frame_t dout,
    output logic   empty,
    output logic   full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    frame_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            push_ok;
    logic            pop_ok;

    // A push while full is refused even if a pop frees a slot that cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    assign dout    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full    <= (count_d == CW'(DEPTH));
            empty   <= (count_d == '0);
        end
    end

endmodule

// File: rtl/viterbi_sequencer.sv
// Feeds buffered classifier frames to the Viterbi decoder one step at a time
// and captures the decoded word once the last frame has been stepped.
module viterbi_sequencer
    import viterbi_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_LEN    = 15,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    viterbi_sequencer_if.slave  bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    len_t             len_q, len_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    frame_t           op_q, op_d;
    logic             start_q, start_d;
    logic             next_q, next_d;
    logic             seqv_q, seqv_d;
    seq_t             seq_q, seq_d;
    len_t             olen_q, olen_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic             pop_c;
    logic             flush_c;
    logic             push_c;
    logic             empty;
    logic             full;
    frame_t           frm_in;
    frame_t           head;

    assign frm_in = {bus.frm_char, bus.frm_prob, bus.frm_last};
    assign push_c = bus.frm_valid & ~full;

    viterbi_sequencer_frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_c),
        .push  (push_c),
        .din   (frm_in),
        .pop   (pop_c),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            timer_q <= '0;
            op_q    <= '0;
            start_q <= 1'b0;
            next_q  <= 1'b0;
            seqv_q  <= 1'b0;
            seq_q   <= '0;
            olen_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            timer_q <= timer_d;
            op_q    <= op_d;
            start_q <= start_d;
            next_q  <= next_d;
            seqv_q  <= seqv_d;
            seq_q   <= seq_d;
            olen_q  <= olen_d;
            err_q   <= err_d;
        end
    end

    // Next-state and registered-output logic; pulses default low so they last one cycle.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        timer_d = timer_q;
        op_d    = op_q;
        start_d = 1'b0;
        next_d  = 1'b0;
        seqv_d  = 1'b0;
        seq_d   = seq_q;
        olen_d  = olen_q;
        err_d   = err_q;
        pop_c   = 1'b0;
        flush_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!empty) begin
                    pop_c = 1'b1;
                    if (len_q == LEN_W'(MAX_LEN)) begin
                        // Word already full: drop the frame, finish only on its last flag.
                        err_d[1] = 1'b1;
                        if (head.last) state_d = ST_DONE;
                    end else begin
                        op_d    = head;
                        start_d = (len_q == '0);
                        next_d  = (len_q != '0);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.vit_stepped) begin
                    len_d   = len_q + LEN_W'(1);
                    timer_d = '0;
                    state_d = op_q.last ? ST_DONE : ST_LOAD;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d[0] = 1'b1;
                    flush_c  = 1'b1;
                    len_d    = '0;
                    timer_d  = '0;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                seq_d   = bus.vit_seq;
                olen_d  = len_q;
                seqv_d  = 1'b1;
                len_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.frm_ready = ~full;
    assign bus.vit_start = start_q;
    assign bus.vit_next  = next_q;
    assign bus.vit_char  = op_q.chars;
    assign bus.vit_prob  = op_q.probs;
    assign bus.seq_valid = seqv_q;
    assign bus.seq       = seq_q;
    assign bus.len       = olen_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_viterbi_sequencer.sv
// Directed bench for viterbi_sequencer: frame table plus hand-written corner sequences.
module tb_viterbi_sequencer;
    import viterbi_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    viterbi_sequencer_if bus();

    viterbi_sequencer #(
        .FIFO_DEPTH (4),
        .MAX_LEN    (15),
        .TIMEOUT    (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        char_arr_t  ch;
        prob_arr_t  pr;
        logic       last;
        logic [1:0] exp_pulse;  // {start,next}
        int         exp_len;    // o_len expected after this frame if last
    } vec_t;

    vec_t tbl [11];
    int   total = 0;
    int   bad   = 0;
    seq_t exp_seq;
    bit   push_done;

    function automatic char_arr_t mkch(input int a, input int b, input int c);
        char_arr_t r;
        r[0] = CHAR_W'(a);
        r[1] = CHAR_W'(b);
        r[2] = CHAR_W'(c);
        return r;
    endfunction

    function automatic prob_arr_t mkpr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        prob_arr_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        return r;
    endfunction

    function automatic vec_t mk(input char_arr_t ch, input prob_arr_t pr, input logic last,
                                input logic [1:0] pulse, input int len);
        vec_t v;
        v.ch = ch; v.pr = pr; v.last = last; v.exp_pulse = pulse; v.exp_len = len;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input char_arr_t ch, input prob_arr_t pr, input logic last);
        int n = 0;
        bus.frm_char  = ch;
        bus.frm_prob  = pr;
        bus.frm_last  = last;
        bus.frm_valid = 1'b1;
        while (!bus.frm_ready && n < 2000) begin
            step();
            n++;
        end
        chk("push_ready", 128'(bus.frm_ready), 128'(1));
        step();
        bus.frm_valid = 1'b0;
    endtask

    task automatic wait_pulse(output logic [1:0] kind);
        int n = 0;
        while (!(bus.vit_start || bus.vit_next) && n < 300) begin
            step();
            n++;
        end
        kind = {bus.vit_start, bus.vit_next};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"}, 128'(bus.vit_start), 128'(0));
        chk({tag, "_next"},  128'(bus.vit_next),  128'(0));
        chk({tag, "_char"},  128'(bus.vit_char),  128'(0));
        chk({tag, "_prob"},  128'(bus.vit_prob),  128'(0));
        chk({tag, "_sv"},    128'(bus.seq_valid), 128'(0));
        chk({tag, "_seq"},   128'(bus.seq),       128'(0));
        chk({tag, "_len"},   128'(bus.len),       128'(0));
        chk({tag, "_err"},   128'(bus.err),       128'(0));
        chk({tag, "_ready"}, 128'(bus.frm_ready), 128'(1));
    endtask

    // Decoder model: checks each issued step against the table, then acknowledges it.
    task automatic vit_side(input int first, input int n, input int delay, input bit issued);
        logic [1:0] kind;
        bit         stable;
        bit         extra;
        int         w;
        vec_t       v;
        for (int k = 0; k < n; k++) begin
            v = tbl[first + k];
            if (!(k == 0 && issued)) begin
                wait_pulse(kind);
                chk($sformatf("pulse[%0d]", first + k), 128'(kind), 128'(v.exp_pulse));
            end
            chk($sformatf("op_char[%0d]", first + k), 128'(bus.vit_char), 128'(v.ch));
            chk($sformatf("op_prob[%0d]", first + k), 128'(bus.vit_prob), 128'(v.pr));
            stable = 1'b1;
            for (int d = 0; d < delay; d++) begin
                step();
                if (bus.vit_char !== v.ch || bus.vit_prob !== v.pr || bus.vit_start || bus.vit_next)
                    stable = 1'b0;
            end
            chk($sformatf("hold[%0d]", first + k), 128'(stable), 128'(1));
            bus.vit_stepped = 1'b1;
            step();
            bus.vit_stepped = 1'b0;
        end
        w = 0;
        extra = 1'b0;
        while (!bus.seq_valid && w < 50) begin
            step();
            w++;
            if (bus.vit_start || bus.vit_next) extra = 1'b1;
        end
        chk("seq_valid", 128'(bus.seq_valid), 128'(1));
        chk("no_extra_pulse", 128'(extra), 128'(0));
        chk("o_len", 128'(bus.len), 128'(v.exp_len));
        chk("o_seq", 128'(bus.seq), 128'(exp_seq));
        step();
        chk("seq_valid_1cyc", 128'(bus.seq_valid), 128'(0));
        chk("o_len_hold", 128'(bus.len), 128'(v.exp_len));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] kind;
        int         cnt;
        bit         sv;
        bit         extra;

        tbl[0]  = mk(mkch(19, 4, 18), mkpr(32'h1028F, 32'hE625, 32'hB7BC), 1'b1, 2'b10, 1);
        tbl[1]  = mk(mkch(19, 4, 18), mkpr(32'h1028F, 32'hE625, 32'hB7BC), 1'b0, 2'b10, 0);
        tbl[2]  = mk(mkch(7, 10, 3),  mkpr(32'h20000, 32'h1100, 32'h0A80),  1'b0, 2'b01, 0);
        tbl[3]  = mk(mkch(8, 18, 24), mkpr(32'h18800, 32'h7700, 32'h0123),  1'b0, 2'b01, 0);
        tbl[4]  = mk(mkch(19, 4, 18), mkpr(32'h0FF00, 32'h0E00, 32'h0D00),  1'b1, 2'b01, 4);
        tbl[5]  = mk(mkch(0, 1, 2),   mkpr(32'h00100, 32'h00200, 32'h00300), 1'b0, 2'b10, 0);
        tbl[6]  = mk(mkch(3, 4, 5),   mkpr(32'h00400, 32'h00500, 32'h00600), 1'b0, 2'b01, 0);
        tbl[7]  = mk(mkch(6, 7, 8),   mkpr(32'h00700, 32'h00800, 32'h00900), 1'b0, 2'b01, 0);
        tbl[8]  = mk(mkch(9, 10, 11), mkpr(32'h00A00, 32'h00B00, 32'h00C00), 1'b0, 2'b01, 0);
        tbl[9]  = mk(mkch(12, 13, 14), mkpr(32'h00D00, 32'h00E00, 32'h00F00), 1'b0, 2'b01, 0);
        tbl[10] = mk(mkch(25, 24, 23), mkpr(32'hFFFF00, 32'h1, 32'h2),     1'b1, 2'b01, 6);

        bus.frm_valid   = 1'b0;
        bus.frm_char    = '0;
        bus.frm_prob    = '0;
        bus.frm_last    = 1'b0;
        bus.vit_stepped = 1'b0;
        bus.vit_seq     = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_reset_outputs("rst0");

        // Single-frame word with push-to-start latency check.
        exp_seq = 120'h13_04_12_00_00_00_00_00_00_00_00_00_00_00_13;
        bus.vit_seq = exp_seq;
        chk("t1_ready", 128'(bus.frm_ready), 128'(1));
        bus.frm_char = tbl[0].ch; bus.frm_prob = tbl[0].pr; bus.frm_last = tbl[0].last;
        bus.frm_valid = 1'b1;
        step();
        bus.frm_valid = 1'b0;
        chk("lat_c1", 128'({bus.vit_start, bus.vit_next}), 128'(0));
        step();
        chk("lat_c2", 128'({bus.vit_start, bus.vit_next}), 128'(0));
        step();
        chk("lat_c3", 128'({bus.vit_start, bus.vit_next}), 128'(2'b10));
        vit_side(0, 1, 5, 1'b1);

        // Four-frame word pushed back-to-back.
        exp_seq = 120'hAB_CD_EF_01_23_45_67_89_13_18_08_03_0A_07_13;
        bus.vit_seq = exp_seq;
        fork
            begin
                for (int k = 1; k < 5; k++) push_frame(tbl[k].ch, tbl[k].pr, tbl[k].last);
            end
            vit_side(1, 4, 3, 1'b0);
        join

        // Backpressure: decoder stalled on the first frame while five more arrive.
        exp_seq = 120'h0055AA;
        bus.vit_seq = exp_seq;
        push_done = 1'b0;
        fork
            begin
                for (int k = 5; k < 11; k++) push_frame(tbl[k].ch, tbl[k].pr, tbl[k].last);
                push_done = 1'b1;
            end
        join_none
        wait_pulse(kind);
        chk("bp_start", 128'(kind), 128'(2'b10));
        repeat (15) step();
        chk("bp_ready_low", 128'(bus.frm_ready), 128'(0));
        chk("bp_push_pending", 128'(push_done), 128'(0));
        vit_side(5, 6, 2, 1'b1);
        cnt = 0;
        while (!push_done && cnt < 100) begin
            step();
            cnt++;
        end
        chk("bp_push_done", 128'(push_done), 128'(1));

        // Timeout: no step acknowledge.
        exp_seq = 120'h77;
        bus.vit_seq = exp_seq;
        push_frame(tbl[0].ch, tbl[0].pr, tbl[0].last);
        wait_pulse(kind);
        chk("to_start", 128'(kind), 128'(2'b10));
        cnt = 0;
        sv = 1'b0;
        while (bus.err == 2'b00 && cnt < 400) begin
            step();
            cnt++;
            if (bus.seq_valid) sv = 1'b1;
        end
        chk("to_cycles", 128'(cnt), 128'(256));
        chk("to_err", 128'(bus.err), 128'(2'b01));
        chk("to_no_seq", 128'(sv), 128'(0));
        push_frame(tbl[0].ch, tbl[0].pr, tbl[0].last);
        vit_side(0, 1, 3, 1'b0);
        chk("to_err_sticky", 128'(bus.err), 128'(2'b01));

        // Overflow: 17-frame word.
        exp_seq = {15{8'hA5}};
        bus.vit_seq = exp_seq;
        fork
            begin
                for (int k = 0; k < 17; k++)
                    push_frame(mkch(k, (k + 1) % 26, (k + 2) % 26),
                               mkpr(32'(k * 256), 32'(k), 32'h5), k == 16);
            end
            begin
                for (int k = 0; k < 15; k++) begin
                    wait_pulse(kind);
                    chk($sformatf("ovf_pulse[%0d]", k), 128'(kind),
                        128'((k == 0) ? 2'b10 : 2'b01));
                    chk($sformatf("ovf_char[%0d]", k), 128'(bus.vit_char[0]), 128'(k));
                    step();
                    bus.vit_stepped = 1'b1;
                    step();
                    bus.vit_stepped = 1'b0;
                end
                cnt = 0;
                extra = 1'b0;
                while (!bus.seq_valid && cnt < 100) begin
                    step();
                    cnt++;
                    if (bus.vit_start || bus.vit_next) extra = 1'b1;
                end
                chk("ovf_seq_valid", 128'(bus.seq_valid), 128'(1));
                chk("ovf_no_pulse", 128'(extra), 128'(0));
                chk("ovf_len", 128'(bus.len), 128'(15));
                chk("ovf_err", 128'(bus.err), 128'(2'b11));
                chk("ovf_seq", 128'(bus.seq), 128'(exp_seq));
            end
        join

        // Reset in WAIT of frame 2, with a third frame still buffered.
        push_frame(tbl[1].ch, tbl[1].pr, tbl[1].last);
        push_frame(tbl[2].ch, tbl[2].pr, tbl[2].last);
        wait_pulse(kind);
        chk("r6_start", 128'(kind), 128'(2'b10));
        push_frame(tbl[3].ch, tbl[3].pr, tbl[3].last);
        bus.vit_stepped = 1'b1;
        step();
        bus.vit_stepped = 1'b0;
        wait_pulse(kind);
        chk("r6_next", 128'(kind), 128'(2'b01));
        chk("r6_op", 128'(bus.vit_char), 128'(tbl[2].ch));
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst6");
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.vit_start || bus.vit_next) extra = 1'b1;
        end
        chk("r6_flushed", 128'(extra), 128'(0));
        exp_seq = 120'h1234;
        bus.vit_seq = exp_seq;
        push_frame(tbl[0].ch, tbl[0].pr, tbl[0].last);
        vit_side(0, 1, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
